imem_loader_ctrl: RTL

Sequencer that owns the instruction-image reload path: when the UART RX FIFO reports a full 512-byte image, it holds the CPU in reset, streams the FIFO contents byte-by-byte into unified memory, acknowledges the UART, and releases the CPU after a fixed hold. It also arbitrates the single memory write port between the CPU store path and the loader. It sits in `top` between `uart`, `uart_fifo`, `risc_v` and `memory`.

---
 rtl/imem_loader_ctrl.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader_ctrl.sv
// Instruction-image reload sequencer: streams a full UART FIFO image into memory while
// holding the CPU in reset, and arbitrates the memory write port. Option: IMEM_LOADER_CHECKSUM_EN.
module imem_loader_ctrl #(
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned ADDR_W      = 9,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fifo_full,
  output logic              fifo_full_ack,
  output logic              fifo_addr_sel,
  output logic [ADDR_W-1:0] fifo_raddr,
  input  logic [7:0]        fifo_rd,
  input  logic              cpu_mem_wen,
  input  logic [31:0]       cpu_mem_wa,
  input  logic [31:0]       cpu_mem_wd,
  input  logic [2:0]        cpu_mem_funct3,
  output logic              mem_wen,
  output logic [31:0]       mem_wa,
  output logic [31:0]       mem_wd,
  output logic [2:0]        mem_funct3,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              load_done,
  output logic              checksum_err
);

  localparam int unsigned       CNT_W     = 8;
  localparam logic [CNT_W-1:0]  HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_ACK,
    S_WAIT_CLR,
    S_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              addr_sel_q, addr_sel_d;
  logic              ack_q, ack_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Byte being written lags the issued FIFO address by one (registered FIFO read).
  logic [ADDR_W-1:0] wr_idx;
  logic [31:0]       wr_addr;
  logic              hold_block;

  assign wr_idx  = raddr_q - ADDR_W'(1);
  assign wr_addr = BASE_ADDR + 32'(wr_idx);

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       err_q, err_d;
  assign hold_block   = err_q;
  assign checksum_err = err_q;
`else
  assign hold_block   = 1'b0;
  assign checksum_err = 1'b0;
`endif

  assign fifo_full_ack = ack_q;
  assign fifo_addr_sel = addr_sel_q;
  assign fifo_raddr    = raddr_q;
  assign cpu_reset_n   = cpu_rst_n_q;
  assign busy          = busy_q;
  assign load_done     = done_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_BOOT;
      raddr_q     <= '0;
      addr_sel_q  <= 1'b0;
      ack_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      cnt_q       <= HOLD_INIT;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      addr_sel_q  <= addr_sel_d;
      ack_q       <= ack_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end
`endif

  // Next-state, registered-output next values and the memory write mux
  always_comb begin
    state_d     = state_q;
    raddr_d     = raddr_q;
    addr_sel_d  = addr_sel_q;
    ack_d       = 1'b0;
    cpu_rst_n_d = cpu_rst_n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    mem_wen     = 1'b0;
    mem_wa      = '0;
    mem_wd      = '0;
    mem_funct3  = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    err_d       = err_q;
`endif

    case (state_q)
      S_BOOT: begin
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          cpu_rst_n_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_IDLE: begin
        if (fifo_full) begin
          state_d     = S_STREAM;
          raddr_d     = '0;
          addr_sel_d  = 1'b1;
          cpu_rst_n_d = 1'b0;
          busy_d      = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d       = '0;
`endif
        end else begin
          mem_wen    = cpu_mem_wen;
          mem_wa     = cpu_mem_wa;
          mem_wd     = cpu_mem_wd;
          mem_funct3 = cpu_mem_funct3;
        end
      end

      S_STREAM: begin
        if (!fifo_full) begin
          state_d    = S_HOLD;
          addr_sel_d = 1'b0;
          cnt_d      = HOLD_INIT;
        end else begin
          raddr_d = raddr_q + ADDR_W'(1);
          if (raddr_q != '0) begin
            mem_wen = 1'b1;
            mem_wa  = wr_addr;
            mem_wd  = {24'b0, fifo_rd};
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_d   = sum_q + fifo_rd;
`endif
          end
          if (raddr_q == LAST_ADDR) begin
            state_d = S_DRAIN;
          end
        end
      end

      // Final byte arrives here; with the checksum option it is the expected sum
      S_DRAIN: begin
        if (!fifo_full) begin
          state_d    = S_HOLD;
          addr_sel_d = 1'b0;
          cnt_d      = HOLD_INIT;
        end else begin
          mem_wen    = 1'b1;
          mem_wa     = wr_addr;
          mem_wd     = {24'b0, fifo_rd};
          state_d    = S_ACK;
          ack_d      = 1'b1;
          addr_sel_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          err_d      = (sum_q != fifo_rd);
`endif
        end
      end

      S_ACK: begin
        state_d = S_WAIT_CLR;
      end

      S_WAIT_CLR: begin
        if (!fifo_full) begin
          state_d = S_HOLD;
          done_d  = 1'b1;
          cnt_d   = HOLD_INIT;
        end
      end

      // A failed checksum parks here until a fresh image arrives
      S_HOLD: begin
        if (hold_block && fifo_full) begin
          state_d    = S_STREAM;
          raddr_d    = '0;
          addr_sel_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
        end else if (cnt_q == '0) begin
          if (!hold_block) begin
            state_d     = S_IDLE;
            cpu_rst_n_d = 1'b1;
            busy_d      = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

endmodule
